sum_bcd_converter: RTL

SUM_BCD_CONVERTER -- requirements
Module: sum_bcd_converter

---
 rtl/sum_bcd_converter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sum_bcd_converter.sv
// sum_bcd_converter
//   Converts a 32-bit unsigned sum into 8 packed BCD digits using a
//   sequential double-dabble over 32 clock edges.
//
//   The done_in level may come from a slower, divided-clock domain. It is
//   synchronised, and only its rising edge starts a conversion, and only
//   while the converter is idle. Each result stays on bcd_out/overflow until
//   the next conversion completes.
//
// Parameters
//   SAT_EN   1: clamp bcd_out to 0x99999999 when the sum exceeds 8 digits
//            0: present the low 8 digits unmodified
// Ports
//   clk      system clock, rising-edge active
//   rst      asynchronous active-low reset
//   done_in  completion level from the summing controller
//   sum_in   binary sum; captured on the trigger edge
//   bcd_out  8 packed BCD digits, most significant digit in [31:28]
//   valid    bcd_out holds a completed conversion
//   busy     conversion in progress
//   overflow last converted sum exceeded 99,999,999

module sum_bcd_converter #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_in,
    input  logic [31:0] sum_in,
    output logic [31:0] bcd_out,
    output logic        valid,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic {StIdle, StConv} state_e;

    state_e      state_q, state_d;
    logic        s1_q, s2_q, s3_q;
    logic        s1_d, s2_d, s3_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] bin_q, bin_d;
    logic [39:0] scr_q, scr_d;
    logic [31:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;

    logic [39:0] scr_adj;
    logic [39:0] scr_step;
    logic        step_ovf;
    logic        trigger;

    always_comb begin
        // Double-dabble correction: every digit >= 5 gets +3 before the shift.
        for (int i = 0; i < 10; i++) begin
            scr_adj[i*4 +: 4] = (scr_q[i*4 +: 4] >= 4'd5) ? scr_q[i*4 +: 4] + 4'd3
                                                            : scr_q[i*4 +: 4];
        end
        scr_step = {scr_adj[38:0], bin_q[31]};
        step_ovf = |scr_step[39:32];

        // s3 holds the previous s2, so a held-high level only triggers once.
        trigger = s2_q & ~s3_q & (state_q == StIdle);

        state_d = state_q;
        s1_d    = done_in;
        s2_d    = s1_q;
        s3_d    = s2_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d = StConv;
                    bin_d   = sum_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            StConv: begin
                scr_d = scr_step;
                bin_d = {bin_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                // Last of 32 steps: publish the post-step scratch.
                if (cnt_q == 5'd31) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    ovf_d   = step_ovf;
                    bcd_d   = (SAT_EN && step_ovf) ? 32'h9999_9999 : scr_step[31:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bcd_out  = bcd_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule
